// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared constants, state encoding and helpers for the PC sequencer
package pc_sequencer_pkg;

    localparam logic [31:0] WORD_ZERO = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_redirect_select.sv
// rtl/pc_sequencer_redirect_select.sv - jump/branch priority, target alignment and misalign detect
module pc_sequencer_redirect_select
    import pc_sequencer_pkg::*;
(
    input  logic        jump_valid_i,
    input  logic [31:0] jump_target_i,
    input  logic        branch_valid_i,
    input  logic [31:0] branch_target_i,
    output logic        redir_o,
    output logic [31:0] tgt_o,
    output logic        misalign_o
);

    logic [31:0] raw_tgt;

    always_comb begin
        // Jump wins when both redirects arrive together
        raw_tgt    = jump_valid_i ? jump_target_i : branch_target_i;
        redir_o    = jump_valid_i | branch_valid_i;
        tgt_o      = align_word(raw_tgt);
        misalign_o = redir_o && (raw_tgt[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC write and instruction fetch sequencer for the multi-cycle datapath
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = pc_sequencer_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        pc_we,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        misalign_err
);
    import pc_sequencer_pkg::*;

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        misalign_q, misalign_d;

    logic        redir;
    logic [31:0] tgt;
    logic        sel_misalign;
    logic        eff_redir;
    logic [31:0] eff_tgt;

    pc_sequencer_redirect_select u_redirect_select (
        .jump_valid_i    (jump_valid),
        .jump_target_i   (jump_target),
        .branch_valid_i  (branch_valid),
        .branch_target_i (branch_target),
        .redir_o         (redir),
        .tgt_o           (tgt),
        .misalign_o      (sel_misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            pending_q  <= 1'b0;
            pend_tgt_q <= WORD_ZERO;
            instr_q    <= WORD_ZERO;
            ipc_q      <= WORD_ZERO;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            pend_tgt_q <= pend_tgt_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pend_tgt_d  = pend_tgt_q;
        instr_d     = instr_q;
        ipc_d       = ipc_q;
        misalign_d  = misalign_q | sel_misalign;
        pc_we       = 1'b0;
        pc_next     = RESET_VECTOR;
        imem_req    = 1'b0;
        instr_valid = 1'b0;

        // A live redirect supersedes one held from earlier in the fetch
        eff_redir = redir | pending_q;
        eff_tgt   = redir ? tgt : pend_tgt_q;

        case (state_q)
            ST_INIT: begin
                pc_we   = 1'b1;
                pc_next = RESET_VECTOR;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (eff_redir) begin
                        pc_we     = 1'b1;
                        pc_next   = eff_tgt;
                        pending_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_cur;
                        state_d = ST_ISSUE;
                    end
                end else if (redir) begin
                    pend_tgt_d = tgt;
                    pending_d  = 1'b1;
                end
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (redir) begin
                    pc_we   = 1'b1;
                    pc_next = tgt;
                    state_d = ST_FETCH;
                end else if (instr_ready) begin
                    pc_we   = 1'b1;
                    pc_next = pc_cur + PC_STEP;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Outputs go quiet the moment reset asserts, not at the next edge
        if (!rst) begin
            pc_we       = 1'b0;
            pc_next     = RESET_VECTOR;
            imem_req    = 1'b0;
            instr_valid = 1'b0;
        end

        imem_addr = imem_req ? pc_cur : WORD_ZERO;
    end

    assign instr_out    = instr_q;
    assign instr_pc     = ipc_q;
    assign misalign_err = misalign_q;

endmodule
